// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter with bounded bursts. It drives the 2:1 select
// and registers the chosen word into a one-entry output slice.
module mux_rr_arbiter #(
  parameter  int MAX_BURST = 4,
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_src,
  input  logic        out_ready,
  output logic        sel
);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  state_t           state, state_next, other_state;
  logic [CNT_W-1:0] burst_cnt, cnt_next, burst_inc;
  logic             last_src, last_next;
  logic             slot_free, grant_src, grant_valid, other_valid, grant_fire;
  logic             a_fire, b_fire;

  // Readiness depends only on state and the output slice, never on the valids.
  assign slot_free = !out_valid || out_ready;
  assign a_ready   = (state == GRANT_A) && slot_free;
  assign b_ready   = (state == GRANT_B) && slot_free;
  assign sel       = (state == GRANT_B);
  assign a_fire    = a_valid && a_ready;
  assign b_fire    = b_valid && b_ready;

  always_comb begin
    state_next  = state;
    cnt_next    = burst_cnt;
    last_next   = last_src;
    grant_src   = (state == GRANT_B);
    grant_valid = grant_src ? b_valid : a_valid;
    other_valid = grant_src ? a_valid : b_valid;
    grant_fire  = a_fire || b_fire;
    other_state = grant_src ? GRANT_A : GRANT_B;
    burst_inc   = burst_cnt + CNT_W'(1);
    case (state)
      IDLE: begin
        cnt_next = '0;
        // last_src names the most recent yielder, so a tie goes to the other side.
        if (a_valid && b_valid) state_next = last_src ? GRANT_A : GRANT_B;
        else if (a_valid)       state_next = GRANT_A;
        else if (b_valid)       state_next = GRANT_B;
      end
      GRANT_A, GRANT_B: begin
        if (grant_fire) begin
          if (burst_inc == MAX_CNT) begin
            cnt_next = '0;
            if (other_valid) begin
              state_next = other_state;
              last_next  = grant_src;
            end
          end else begin
            cnt_next = burst_inc;
          end
        end else if (!grant_valid) begin
          last_next  = grant_src;
          cnt_next   = '0;
          state_next = other_valid ? other_state : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      burst_cnt <= '0;
      last_src  <= 1'b1;
    end else begin
      state     <= state_next;
      burst_cnt <= cnt_next;
      last_src  <= last_next;
    end
  end

  // Output slice: loading a new beat and draining the old one can share an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
    end else if (a_fire) begin
      out_valid <= 1'b1;
      out_data  <= a_data;
      out_src   <= 1'b0;
    end else if (b_fire) begin
      out_valid <= 1'b1;
      out_data  <= b_data;
      out_src   <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (MAX_BURST = 4): a hand-computed vector table
// plus short sequences for reset, lone requester, backpressure and early yield.
module tb_mux_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, out_ready;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, out_valid, out_src, sel;
  logic [31:0] out_data;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic        av;
    logic [31:0] ad;
    logic        bv;
    logic [31:0] bd;
    logic        rdy;
    logic        ar;
    logic        br;
    logic        sl;
    logic        ov;
    logic [31:0] od;
    logic        os;
  } vec_t;

  vec_t vecs[15];

  mux_rr_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .sel(sel)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input logic av, input logic [31:0] ad, input logic bv,
                                 input logic [31:0] bd, input logic rdy, input logic ar,
                                 input logic br, input logic sl, input logic ov,
                                 input logic [31:0] od, input logic os);
    vec_t v;
    v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.rdy = rdy;
    v.ar = ar; v.br = br; v.sl = sl; v.ov = ov; v.od = od; v.os = os;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [31:0] ad, input logic bv,
                               input logic [31:0] bd, input logic rdy);
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = rdy;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    reset = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic fired;
    int   sent;
    localparam logic [31:0] A = 32'hA000_0000;
    localparam logic [31:0] B = 32'hB000_0000;

    vecs[0]  = mkVec(1, A+0, 1, B+0, 1,  0, 0, 0,  0, 32'h0, 0);
    vecs[1]  = mkVec(1, A+0, 1, B+0, 1,  1, 0, 0,  0, 32'h0, 0);
    vecs[2]  = mkVec(1, A+1, 1, B+0, 1,  1, 0, 0,  1, A+0, 0);
    vecs[3]  = mkVec(1, A+2, 1, B+0, 1,  1, 0, 0,  1, A+1, 0);
    vecs[4]  = mkVec(1, A+3, 1, B+0, 1,  1, 0, 0,  1, A+2, 0);
    vecs[5]  = mkVec(1, A+4, 1, B+0, 1,  0, 1, 1,  1, A+3, 0);
    vecs[6]  = mkVec(1, A+4, 1, B+1, 1,  0, 1, 1,  1, B+0, 1);
    vecs[7]  = mkVec(1, A+4, 1, B+2, 1,  0, 1, 1,  1, B+1, 1);
    vecs[8]  = mkVec(1, A+4, 1, B+3, 1,  0, 1, 1,  1, B+2, 1);
    vecs[9]  = mkVec(1, A+4, 1, B+4, 1,  1, 0, 0,  1, B+3, 1);
    vecs[10] = mkVec(1, A+5, 1, B+4, 1,  1, 0, 0,  1, A+4, 0);
    vecs[11] = mkVec(1, A+6, 1, B+4, 1,  1, 0, 0,  1, A+5, 0);
    vecs[12] = mkVec(1, A+7, 1, B+4, 1,  1, 0, 0,  1, A+6, 0);
    vecs[13] = mkVec(0, 32'h0, 0, 32'h0, 1,  0, 1, 1,  1, A+7, 0);
    vecs[14] = mkVec(0, 32'h0, 0, 32'h0, 1,  0, 0, 0,  0, A+7, 0);

    // Tie from reset, burst alternation, then both drop back to IDLE.
    doReset();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd, vecs[i].rdy);
      checkBit($sformatf("vec%0d a_ready", i), a_ready, vecs[i].ar);
      checkBit($sformatf("vec%0d b_ready", i), b_ready, vecs[i].br);
      checkBit($sformatf("vec%0d sel", i), sel, vecs[i].sl);
      checkBit($sformatf("vec%0d out_valid", i), out_valid, vecs[i].ov);
      checkOutput($sformatf("vec%0d out_data", i), out_data, vecs[i].od);
      checkBit($sformatf("vec%0d out_src", i), out_src, vecs[i].os);
      tick();
    end

    // Lone requester A: ten back-to-back words across a burst restart.
    doReset();
    sent = 0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(sent < 10, A + 32'(sent), 1'b0, 32'h0, 1'b1);
      checkBit($sformatf("lone c%0d sel", c), sel, 1'b0);
      if (c >= 1) checkBit($sformatf("lone c%0d a_ready", c), a_ready, 1'b1);
      if (c >= 2) begin
        checkBit($sformatf("lone c%0d out_valid", c), out_valid, 1'b1);
        checkOutput($sformatf("lone c%0d out_data", c), out_data, A + 32'(c - 2));
      end
      fired = a_valid && a_ready;
      tick();
      if (fired) sent++;
    end
    checkOutput("lone words sent", 32'(sent), 32'd10);

    // Backpressure: stall holds the slice and does not consume burst budget.
    doReset();
    applyStimulus(1, 32'h1234_5678, 0, 32'h0, 1);
    checkBit("bp c0 a_ready", a_ready, 1'b0);
    tick();
    applyStimulus(1, 32'h1234_5678, 0, 32'h0, 1);
    checkBit("bp c1 a_ready", a_ready, 1'b1);
    tick();
    for (int c = 2; c < 5; c++) begin
      applyStimulus(1, 32'h0BAD_F00D, 0, 32'h0, 0);
      checkBit($sformatf("bp c%0d a_ready", c), a_ready, 1'b0);
      checkBit($sformatf("bp c%0d out_valid", c), out_valid, 1'b1);
      checkOutput($sformatf("bp c%0d out_data", c), out_data, 32'h1234_5678);
      tick();
    end
    applyStimulus(1, 32'h0BAD_F00D, 0, 32'h0, 1);
    checkBit("bp c5 a_ready", a_ready, 1'b1);
    checkOutput("bp c5 out_data", out_data, 32'h1234_5678);
    tick();
    applyStimulus(1, A+2, 1, B+0, 1);
    checkOutput("bp c6 out_data", out_data, 32'h0BAD_F00D);
    checkBit("bp c6 sel", sel, 1'b0);
    tick();
    applyStimulus(1, A+3, 1, B+0, 1);
    checkOutput("bp c7 out_data", out_data, A+2);
    checkBit("bp c7 sel", sel, 1'b0);
    tick();
    applyStimulus(1, A+4, 1, B+0, 1);
    checkOutput("bp c8 out_data", out_data, A+3);
    checkBit("bp c8 sel", sel, 1'b1);
    checkBit("bp c8 b_ready", b_ready, 1'b1);
    tick();

    // Early yield by A, then B yields; the next tie must go back to A.
    doReset();
    applyStimulus(1, A+0, 1, B+0, 1);
    checkBit("ey c0 a_ready", a_ready, 1'b0);
    tick();
    applyStimulus(1, A+0, 1, B+0, 1);
    checkBit("ey c1 a_ready", a_ready, 1'b1);
    tick();
    applyStimulus(1, A+1, 1, B+0, 1);
    checkOutput("ey c2 out_data", out_data, A+0);
    tick();
    applyStimulus(0, 32'h0, 1, B+0, 1);
    checkBit("ey c3 sel", sel, 1'b0);
    checkOutput("ey c3 out_data", out_data, A+1);
    tick();
    applyStimulus(0, 32'h0, 1, B+0, 1);
    checkBit("ey c4 sel", sel, 1'b1);
    checkBit("ey c4 b_ready", b_ready, 1'b1);
    checkBit("ey c4 a_ready", a_ready, 1'b0);
    tick();
    applyStimulus(0, 32'h0, 0, 32'h0, 1);
    checkOutput("ey c5 out_data", out_data, B+0);
    checkBit("ey c5 out_src", out_src, 1'b1);
    tick();
    applyStimulus(1, A+9, 1, B+9, 1);
    checkBit("ey c6 a_ready", a_ready, 1'b0);
    checkBit("ey c6 b_ready", b_ready, 1'b0);
    checkBit("ey c6 out_valid", out_valid, 1'b0);
    tick();
    applyStimulus(1, A+9, 1, B+9, 1);
    checkBit("ey c7 a_ready", a_ready, 1'b1);
    checkBit("ey c7 sel", sel, 1'b0);
    tick();

    // Reset mid-burst in GRANT_B with a word held in the slice.
    doReset();
    applyStimulus(0, 32'h0, 1, B+0, 1);
    tick();
    applyStimulus(0, 32'h0, 1, B+0, 1);
    checkBit("rst c1 b_ready", b_ready, 1'b1);
    tick();
    applyStimulus(0, 32'h0, 1, B+1, 1);
    tick();
    applyStimulus(0, 32'h0, 1, B+2, 0);
    checkBit("rst pre out_valid", out_valid, 1'b1);
    checkBit("rst pre sel", sel, 1'b1);
    checkOutput("rst pre out_data", out_data, B+1);
    reset = 1'b1;
    #1;
    checkBit("rst out_valid", out_valid, 1'b0);
    checkOutput("rst out_data", out_data, 32'h0);
    checkBit("rst out_src", out_src, 1'b0);
    checkBit("rst sel", sel, 1'b0);
    checkBit("rst b_ready", b_ready, 1'b0);
    #1;
    reset = 1'b0;
    applyStimulus(1, A+0, 1, B+0, 1);
    tick();
    checkBit("rst after a_ready", a_ready, 1'b1);
    checkBit("rst after sel", sel, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 32-bit 2:1 select datapath.
- Each requester (A, B) presents 32-bit data with a valid/ready handshake.
- The block owns the select line, grants one requester at a time with a bounded burst length, and registers the selected word into a one-entry output slice with its own valid/ready handshake toward the consumer.

Parameters:
- MAX_BURST, 4, beats a granted requester may transfer before it must yield when the other is waiting; legal range 1..255.
- CNT_W, $clog2(MAX_BURST+1), burst counter width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- a_valid  input  1  requester A has a word
- a_data  input  32  requester A word
- a_ready  output  1  A word accepted this cycle when a_valid && a_ready
- b_valid  input  1  requester B has a word
- b_data  input  32  requester B word
- b_ready  output  1  B word accepted this cycle when b_valid && b_ready
- out_valid  output  1  out_data holds a word
- out_data  output  32  registered selected word
- out_src  output  1  source of out_data: 0 = A, 1 = B
- out_ready  input  1  consumer accepts when out_valid && out_ready
- sel  output  1  datapath select: 0 = A, 1 = B; equals (state == GRANT_B)

Behaviour:
- Reset (async, immediate): state = IDLE, burst_cnt = 0, last_src = 1 (A wins the first tie), out_valid = 0, out_data = 0, out_src = 0. A word held in the slice is discarded; a partial burst is abandoned.
- States: IDLE, GRANT_A, GRANT_B; registered, one-hot or binary.
- slot_free = !out_valid || out_ready.
- a_ready = (state == GRANT_A) && slot_free; b_ready = (state == GRANT_B) && slot_free. Both are 0 in IDLE. They never assert together.
- Accepted beat from X: out_data <= X_data, out_src <= X, out_valid <= 1 at the same edge.
- Consumer accept with no new beat: out_valid <= 0.
- Full throughput: accept and load in the same cycle, one word per clock.
- Latency: request in IDLE at cycle n -> grant at n+1 -> word accepted at edge ending n+1 -> out_valid high in n+2. Inside a grant, data appears on out_data one cycle after acceptance.
- IDLE transitions:
  - both valid -> grant the opposite of last_src;
  - only A valid -> GRANT_A; only B valid -> GRANT_B; neither -> stay in IDLE.
  - burst_cnt <= 0.
- GRANT_X transitions, evaluated per edge, with Y the other requester:
  - X_valid && X_ready: next = burst_cnt + 1.
    - If next == MAX_BURST and Y_valid: go to GRANT_Y, burst_cnt <= 0, last_src <= X.
    - If next == MAX_BURST and !Y_valid: stay, burst_cnt <= 0; the burst restarts.
    - Otherwise burst_cnt <= next.
  - X_valid && !X_ready (output stalled): hold state and burst_cnt. Stall cycles do not count toward the burst.
  - !X_valid: last_src <= X, burst_cnt <= 0; go to GRANT_Y if Y_valid, else IDLE.
- Requester obligations: data stable and valid held until accepted; the arbiter never drops a presented word once granted. Data is sampled only on acceptance.
- out_valid, out_data and out_src hold while out_valid && !out_ready.
- No combinational path from a_valid or b_valid to a_ready or b_ready. The ready outputs depend on state, out_valid and out_ready only.
- MAX_BURST = 1 gives strict per-beat alternation when both requesters are continuously valid.

Test Plan:
- Reset mid-burst: assert reset while in GRANT_B with burst_cnt = 2 and out_valid = 1 -> outputs clear the same cycle. After release, with both valid, A is granted first.
- Tie and alternation: MAX_BURST = 4, both valid, A words 0xA0000000+i, B words 0xB0000000+i, out_ready = 1 -> out_data sequence A0..A3, B0..B3, A4..A7, with out_src matching.
- Lone requester: only A valid for 10 beats -> 10 contiguous A words with no bubble after the first. sel stays 0 and the state never leaves GRANT_A.
- Backpressure: out_ready = 0 for 3 cycles during GRANT_A, with out_data = 0x12345678 loaded -> out_data holds and a_ready = 0. burst_cnt is unchanged after the stall and no word is lost or duplicated.
- Early yield: A drops valid after 2 beats while B is valid -> GRANT_B on the next cycle. The next tie then grants A, because last_src = B is set when B yields.
- Idle return: both requesters drop valid -> IDLE, a_ready = b_ready = 0. out_valid clears after the consumer takes the final word.
